// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter that lets one of N_REQ requesters at a time write a
// burst of words into the write side of a FIFO.
//
// A grant is decided in IDLE and takes effect on the next edge. Each grant
// ends with a release back to IDLE, so there is always at least one IDLE
// cycle between grants. A grant is released when its owner transfers a word
// flagged req_last, or when it transfers its MAX_BURST-th word.
//
// Ports
//   wclk       : clock, all state changes on the rising edge
//   wrst       : asynchronous active-high reset
//   req_valid  : [N_REQ] requester i offers a word
//   req_data   : [N_REQ*DATA_WIDTH] word of requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last   : [N_REQ] offered word of requester i ends its packet
//   req_ready  : [N_REQ] requester i's word is accepted this cycle
//   wfull      : FIFO full flag
//   winc       : FIFO write enable
//   wdata      : FIFO write data (owner's word while granted, 0 in IDLE)
//   grant      : [N_REQ] one-hot current owner, 0 in IDLE
//   busy       : 1 while a grant is held
//   wr_count   : [16] total words written, wraps
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                        wclk,
  input  logic                        wrst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]            req_last,
  output logic [N_REQ-1:0]            req_ready,
  input  logic                        wfull,
  output logic                        winc,
  output logic [DATA_WIDTH-1:0]       wdata,
  output logic [N_REQ-1:0]            grant,
  output logic                        busy,
  output logic [15:0]                 wr_count
);

  localparam int IDX_W = $clog2(N_REQ);
  // Wide enough to hold MAX_BURST-1 for MAX_BURST up to 16.
  localparam int CNT_W = 5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t               state_r;
  logic [IDX_W-1:0]     g_r;
  logic [IDX_W-1:0]     rr_r;
  logic [CNT_W-1:0]     burst_cnt_r;
  logic [15:0]          wr_count_r;
  logic [N_REQ-1:0]     grant_r;
  logic                 busy_r;

  logic [IDX_W-1:0]     pick_idx_s;
  logic                 pick_found_s;
  logic                 xfer_s;
  logic                 release_s;

  // Reduce an integer position into the requester index range.
  function automatic logic [IDX_W-1:0] wrap_idx(input int v);
    return IDX_W'(v % N_REQ);
  endfunction

  // One-hot vector with only bit idx set.
  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = {N_REQ{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin pick: scanning from the farthest offset down to offset 0
  // leaves the valid requester closest to rr as the final choice.
  always_comb begin
    pick_idx_s   = {IDX_W{1'b0}};
    pick_found_s = |req_valid;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      pick_idx_s = req_valid[wrap_idx(int'(rr_r) + i)] ? wrap_idx(int'(rr_r) + i) : pick_idx_s;
    end
  end

  // Transfer and release conditions for the current owner.
  always_comb begin
    xfer_s    = (state_r == ST_GRANT) && req_valid[g_r] && !wfull;
    release_s = xfer_s && (req_last[g_r] || (burst_cnt_r == CNT_W'(MAX_BURST - 1)));
  end

  // Handshake and write-data outputs follow the transfer condition in the same cycle.
  always_comb begin
    req_ready      = {N_REQ{1'b0}};
    req_ready[g_r] = xfer_s;
    winc           = xfer_s;
    if (state_r == ST_GRANT) begin
      wdata = req_data[int'(g_r)*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      wdata = {DATA_WIDTH{1'b0}};
    end
  end

  // Arbitration FSM, burst/word counters and registered grant/busy.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state_r     <= ST_IDLE;
      g_r         <= {IDX_W{1'b0}};
      rr_r        <= {IDX_W{1'b0}};
      burst_cnt_r <= {CNT_W{1'b0}};
      wr_count_r  <= 16'h0000;
      grant_r     <= {N_REQ{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pick_found_s) begin
            state_r     <= ST_GRANT;
            g_r         <= pick_idx_s;
            burst_cnt_r <= {CNT_W{1'b0}};
            grant_r     <= onehot(pick_idx_s);
            busy_r      <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (xfer_s) begin
            wr_count_r  <= wr_count_r + 16'd1;
            burst_cnt_r <= burst_cnt_r + CNT_W'(1);
            if (release_s) begin
              state_r <= ST_IDLE;
              rr_r    <= wrap_idx(int'(g_r) + 1);
              grant_r <= {N_REQ{1'b0}};
              busy_r  <= 1'b0;
            end else begin
              state_r <= ST_GRANT;
            end
          end else begin
            // Stalled by wfull or an idle owner: hold everything, no pre-emption.
            state_r <= ST_GRANT;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          grant_r <= {N_REQ{1'b0}};
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign grant    = grant_r;
  assign busy     = busy_r;
  assign wr_count = wr_count_r;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus random
// traffic, compared against a transaction-level model of owner/rr/counts.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;
  localparam int DW = N * W;

  logic          wclk = 1'b0;
  logic          wrst;
  logic [N-1:0]  req_valid;
  logic [DW-1:0] req_data;
  logic [N-1:0]  req_last;
  logic [N-1:0]  req_ready;
  logic          wfull;
  logic          winc;
  logic [W-1:0]  wdata;
  logic [N-1:0]  grant;
  logic          busy;
  logic [15:0]   wr_count;

  int checks   = 0;
  int failures = 0;

  // Model: owner (-1 = nobody), next-preferred requester, words in this grant, total words.
  int          m_owner;
  int          m_rr;
  int          m_cnt;
  logic [15:0] m_wc;

  fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(W), .MAX_BURST(MB)) dut (
    .wclk      (wclk),
    .wrst      (wrst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .wfull     (wfull),
    .winc      (winc),
    .wdata     (wdata),
    .grant     (grant),
    .busy      (busy),
    .wr_count  (wr_count)
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_rr    = 0;
    m_cnt   = 0;
    m_wc    = 16'h0000;
  endtask

  function automatic bit m_xfer();
    return (m_owner >= 0) && req_valid[m_owner] && !wfull;
  endfunction

  task automatic check_outputs();
    logic [N-1:0] eg;
    logic [N-1:0] er;
    logic [W-1:0] ed;
    eg = '0;
    er = '0;
    ed = '0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      ed = req_data[m_owner*W +: W];
      if (m_xfer()) er[m_owner] = 1'b1;
    end
    chk("grant", grant, eg);
    chk("busy", busy, (m_owner >= 0));
    chk("winc", winc, m_xfer());
    chk("req_ready", req_ready, er);
    chk("wdata", wdata, ed);
    chk("wr_count", wr_count, m_wc);
  endtask

  // Advance the model across one rising edge using the inputs held at that edge.
  task automatic model_edge();
    bit found;
    if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (!found && req_valid[(m_rr + k) % N]) begin
          found   = 1'b1;
          m_owner = (m_rr + k) % N;
          m_cnt   = 0;
        end
      end
    end else if (m_xfer()) begin
      m_wc  = m_wc + 16'd1;
      m_cnt = m_cnt + 1;
      if (req_last[m_owner] || m_cnt == MB) begin
        m_rr    = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic step(input bit do_chk);
    #1;
    if (do_chk) check_outputs();
    @(posedge wclk);
    model_edge();
    @(negedge wclk);
  endtask

  task automatic do_reset();
    wrst      = 1'b1;
    req_valid = '0;
    req_last  = '0;
    wfull     = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(negedge wclk);
    wrst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] exp_g;
    int n;
    wrst      = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = DW'(32'hA1B2C3D4);
    wfull     = 1'b0;
    @(negedge wclk);

    // Reset state and two-requester round robin with max-length bursts.
    do_reset();
    req_valid = 4'b0110;
    for (int c = 0; c < 12; c++) begin
      req_data = DW'($urandom);
      #1;
      if (c == 0 || c == 5 || c == 10) exp_g = 4'b0000;
      else if (c < 5 || c > 10)        exp_g = 4'b0010;
      else                             exp_g = 4'b0100;
      chk("rr2_grant", grant, exp_g);
      chk("rr2_winc", winc, (exp_g != 4'b0000));
      step(1'b1);
    end

    // Two-word packet from requester 0 ended by req_last.
    do_reset();
    req_valid = 4'b0001;
    step(1'b1);
    step(1'b1);
    req_last = 4'b0001;
    step(1'b1);
    req_valid = 4'b0000;
    req_last  = 4'b0000;
    #1;
    chk("pkt_busy", busy, 1'b0);
    chk("pkt_count", wr_count, 16'd2);
    step(1'b1);
    req_valid = 4'b1111;
    step(1'b1);
    #1;
    chk("pkt_next_grant", grant, 4'b0010);

    // FIFO full for three cycles stalls the grant without losing words.
    wfull = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall_winc", winc, 1'b0);
      chk("stall_ready", req_ready, 4'b0000);
      chk("stall_grant", grant, 4'b0010);
      step(1'b1);
    end
    wfull = 1'b0;
    for (int c = 0; c < 5; c++) begin
      req_data = DW'($urandom);
      step(1'b1);
    end
    #1;
    chk("stall_total", wr_count, 16'd6);

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom);
      req_last  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      wfull     = ($urandom_range(0, 3) == 0);
      req_data  = DW'($urandom);
      step(1'b1);
    end

    // All four requesters valid: order 0,1,2,3,0 with four words each.
    do_reset();
    req_valid = 4'b1111;
    for (int c = 0; c < 25; c++) begin
      req_data = DW'($urandom);
      #1;
      exp_g = (c % 5 == 0) ? 4'b0000 : N'(1 << ((c / 5) % 4));
      chk("rr4_grant", grant, exp_g);
      step(1'b1);
    end

    // Reset pulsed during the third word of a burst.
    do_reset();
    req_valid = 4'b0001;
    step(1'b1);
    step(1'b1);
    step(1'b1);
    #1;
    chk("mid_winc_before", winc, 1'b1);
    #1;
    wrst = 1'b1;
    #1;
    chk("mid_grant", grant, 4'b0000);
    chk("mid_busy", busy, 1'b0);
    chk("mid_winc", winc, 1'b0);
    chk("mid_ready", req_ready, 4'b0000);
    chk("mid_wdata", wdata, 8'h00);
    chk("mid_count", wr_count, 16'h0000);
    model_reset();
    @(negedge wclk);
    wrst      = 1'b0;
    req_valid = 4'b0110;
    step(1'b1);
    #1;
    chk("mid_regrant", grant, 4'b0010);

    // Long run of writes to carry wr_count through its wrap point.
    do_reset();
    req_valid = 4'b0001;
    n = 0;
    while (m_wc != 16'hFFFF && n < 90000) begin
      step(1'b0);
      n++;
    end
    #1;
    chk("pre_wrap_count", wr_count, 16'hFFFF);
    n = 0;
    while (m_wc != 16'h0001 && n < 10) begin
      step(1'b1);
      n++;
    end
    #1;
    chk("wrap_count", wr_count, 16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
